// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: recovers digit values from a multiplexed active-low 7-segment bus.
// Define SEG7DEC_HEX_EN to also decode the A,b,C,d,E,F glyphs as 10..15.
module seg7_scan_decoder #(
  parameter int NDIG   = 8,
  parameter int STABLE = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [6:0]        seg_n,
  input  logic [NDIG-1:0]   an_n,
  output logic [4*NDIG-1:0] digits,
  output logic [NDIG-1:0]   dvalid,
  output logic [NDIG-1:0]   derr,
  output logic              upd,
  output logic              frame_valid,
  input  logic              frame_ready,
  output logic [4*NDIG-1:0] frame_digits,
  output logic [NDIG-1:0]   frame_err,
  output logic              frame_ovf
);

  localparam int IW = $clog2(NDIG);
  // Count is cleared on the first cycle after a change, so STABLE-2 precedes the capture edge.
  localparam logic [7:0] CAP_AT = 8'(STABLE - 2);

  logic [6:0]        s_seg, p_seg;
  logic [NDIG-1:0]   s_an, p_an, sel;
  logic [7:0]        cnt;
  logic [NDIG-1:0]   seen, seen_nx;
  logic              legal, same, capture, full, changed;
  logic [IW-1:0]     idx;
  logic [3:0]        dec_val;
  logic              dec_err;
  logic [4*NDIG-1:0] digits_nx;
  logic [NDIG-1:0]   derr_nx;

  // Returns {err, value}; unknown patterns give value 0 with err set.
  function automatic logic [4:0] decode(input logic [6:0] p);
    logic [4:0] r;
    case (p)
      7'b0000001: r = 5'h00;
      7'b1001111: r = 5'h01;
      7'b0010010: r = 5'h02;
      7'b0000110: r = 5'h03;
      7'b1001100: r = 5'h04;
      7'b0100100: r = 5'h05;
      7'b0100000: r = 5'h06;
      7'b0001111: r = 5'h07;
      7'b0000000: r = 5'h08;
      7'b0000100: r = 5'h09;
`ifdef SEG7DEC_HEX_EN
      7'b0001000: r = 5'h0A;
      7'b1100000: r = 5'h0B;
      7'b0110001: r = 5'h0C;
      7'b1000010: r = 5'h0D;
      7'b0110000: r = 5'h0E;
      7'b0111000: r = 5'h0F;
`endif
      default:    r = 5'h10;
    endcase
    return r;
  endfunction

  always_comb begin
    sel   = ~s_an;
    legal = (sel != '0) && ((sel & (sel - NDIG'(1))) == '0);
    idx   = '0;
    for (int i = 0; i < NDIG; i++)
      if (sel[i]) idx = IW'(i);
  end

  assign same    = (s_seg == p_seg) && (s_an == p_an);
  assign capture = same && legal && (cnt == CAP_AT);

  always_comb begin
    {dec_err, dec_val}          = decode(s_seg);
    digits_nx                   = digits;
    derr_nx                     = derr;
    digits_nx[{idx, 2'b00} +: 4] = dec_val;
    derr_nx[idx]                = dec_err;
    changed = (digits[{idx, 2'b00} +: 4] != dec_val) || (derr[idx] != dec_err) || !dvalid[idx];
    seen_nx      = seen;
    seen_nx[idx] = 1'b1;
    full         = &seen_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_seg        <= '1;
      s_an         <= '1;
      p_seg        <= '1;
      p_an         <= '1;
      cnt          <= '0;
      seen         <= '0;
      digits       <= '0;
      dvalid       <= '0;
      derr         <= '0;
      upd          <= 1'b0;
      frame_valid  <= 1'b0;
      frame_digits <= '0;
      frame_err    <= '0;
      frame_ovf    <= 1'b0;
    end else begin
      s_seg <= seg_n;
      s_an  <= an_n;
      p_seg <= s_seg;
      p_an  <= s_an;

      if (!same || !legal)    cnt <= '0;
      else if (cnt != 8'hFF)  cnt <= cnt + 8'd1;

      upd       <= 1'b0;
      frame_ovf <= 1'b0;
      if (frame_valid && frame_ready) frame_valid <= 1'b0;

      if (capture) begin
        digits      <= digits_nx;
        derr        <= derr_nx;
        dvalid[idx] <= 1'b1;
        upd         <= changed;
        if (full) begin
          seen <= '0;
          // A frame completing in the accept cycle replaces the snapshot instead of overflowing.
          if (!frame_valid || frame_ready) begin
            frame_valid  <= 1'b1;
            frame_digits <= digits_nx;
            frame_err    <= derr_nx;
          end else begin
            frame_ovf <= 1'b1;
          end
        end else begin
          seen <= seen_nx;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder (NDIG=8, STABLE=4); follows SEG7DEC_HEX_EN if defined.
module tb_seg7_scan_decoder;
  localparam int NDIG   = 8;
  localparam int STABLE = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [6:0]        seg_n;
  logic [NDIG-1:0]   an_n;
  logic [4*NDIG-1:0] digits;
  logic [NDIG-1:0]   dvalid;
  logic [NDIG-1:0]   derr;
  logic              upd;
  logic              frame_valid;
  logic              frame_ready;
  logic [4*NDIG-1:0] frame_digits;
  logic [NDIG-1:0]   frame_err;
  logic              frame_ovf;

  int checks  = 0;
  int errors  = 0;
  int upd_cnt = 0;
  int ovf_cnt = 0;

  logic [6:0] pat [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                           7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

  seg7_scan_decoder #(.NDIG(NDIG), .STABLE(STABLE)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .seg_n        (seg_n),
    .an_n         (an_n),
    .digits       (digits),
    .dvalid       (dvalid),
    .derr         (derr),
    .upd          (upd),
    .frame_valid  (frame_valid),
    .frame_ready  (frame_ready),
    .frame_digits (frame_digits),
    .frame_err    (frame_err),
    .frame_ovf    (frame_ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (upd)       upd_cnt++;
    if (frame_ovf) ovf_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic show(input logic [6:0] seg, input int d, input int n);
    seg_n = seg;
    an_n  = ~(NDIG'(1) << d);
    repeat (n) @(negedge clk);
  endtask

  task automatic blank(input int n);
    seg_n = '1;
    an_n  = '1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n       = 1'b0;
    seg_n       = '1;
    an_n        = '1;
    frame_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_outputs", {digits, dvalid, derr, upd, frame_valid, frame_ovf}, 64'h0);
    check("rst_frame", {frame_digits, frame_err}, 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    show(pat[2], 2, 25);
    blank(2);
    check("d2_value", digits[11:8], 4'd2);
    check("d2_dvalid", dvalid, 8'h04);
    check("d2_upd_once", upd_cnt, 1);

    show(pat[2], 2, 6);
    blank(2);
    check("d2_same_no_upd", upd_cnt, 1);

    show(pat[3], 3, 3);
    blank(3);
    check("short_dvalid", dvalid, 8'h04);
    check("short_upd", upd_cnt, 1);

    show(pat[3], 3, 4);
    blank(2);
    check("exact_dwell_val", digits[15:12], 4'd3);
    check("exact_dwell_upd", upd_cnt, 2);

    seg_n = pat[5]; an_n = 8'b1111_1100; repeat (10) @(negedge clk);
    seg_n = pat[5]; an_n = 8'hFF;        repeat (10) @(negedge clk);
    seg_n = pat[5]; an_n = 8'h00;        repeat (10) @(negedge clk);
    check("illegal_dvalid", dvalid, 8'h0C);
    check("illegal_upd", upd_cnt, 2);

    show(7'b1111111, 0, 4);
    blank(2);
    check("unknown_derr", derr, 8'h01);
    check("unknown_val", digits[3:0], 4'd0);
    check("unknown_dvalid", dvalid, 8'h0D);

    for (int i = 0; i < NDIG; i++) show(pat[7 - i], i, 5);
    blank(2);
    check("frame1_valid", frame_valid, 1'b1);
    check("frame1_digits", frame_digits, 32'h0123_4567);
    check("frame1_err", frame_err, 8'h00);
    check("frame1_no_ovf", ovf_cnt, 0);

    for (int i = 0; i < NDIG; i++) show(pat[i], i, 5);
    blank(2);
    check("frame2_ovf", ovf_cnt, 1);
    check("frame2_hold", frame_digits, 32'h0123_4567);
    check("frame2_live", digits, 32'h7654_3210);
    check("frame2_valid", frame_valid, 1'b1);

    frame_ready = 1'b1;
    @(negedge clk);
    check("accept_drop", frame_valid, 1'b0);
    frame_ready = 1'b0;

    show(7'b0001000, 1, 4);
    blank(2);
`ifdef SEG7DEC_HEX_EN
    check("hex_a_val", digits[7:4], 4'd10);
    check("hex_a_err", derr[1], 1'b0);
`else
    check("hex_a_val", digits[7:4], 4'd0);
    check("hex_a_err", derr[1], 1'b1);
`endif

    seg_n = pat[8];
    an_n  = ~(NDIG'(1) << 5);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_outputs", {digits, dvalid, derr, upd, frame_valid, frame_ovf}, 64'h0);
    check("midrst_frame", {frame_digits, frame_err}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_no_early", dvalid, 8'h00);
    repeat (2) @(negedge clk);
    check("midrst_capture", dvalid, 8'h20);
    check("midrst_value", digits[23:20], 4'd8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
